// File: rtl/ctrl_pkg.sv
// Shared encodings for the accumulator control unit: FSM states, opcodes,
// R-mux select codes and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    WAIT_M  = 3'd3,
    WAIT_IN = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDM  = 4'h2;
  localparam logic [3:0] OP_STM  = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] SEL_CONST = 3'd0;
  localparam logic [2:0] SEL_MEM   = 3'd1;
  localparam logic [2:0] SEL_IN    = 3'd2;
  localparam logic [2:0] SEL_RES   = 3'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  // ALU opcodes are contiguous, so the ALU code is the offset from ADD
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    logic [3:0] d;
    d = op - OP_ADD;
    return d[2:0];
  endfunction

endpackage

// File: rtl/unidade_controlo_decodificador.sv
// Combinational strobe decoder: maps FSM state, IR opcode and the input-port
// valid flag onto the datapath control strobes.
module decodificador
  import ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_in_valid,
  output logic [2:0] o_sel,
  output logic       o_wr_r,
  output logic       o_we_m,
  output logic [2:0] o_alu_op,
  output logic       o_in_ack,
  output logic       o_halted
);

  always_comb begin
    o_sel    = SEL_CONST;
    o_wr_r   = 1'b0;
    o_we_m   = 1'b0;
    o_alu_op = ALU_ADD;
    o_in_ack = 1'b0;
    o_halted = 1'b0;
    case (i_state)
      EXEC: begin
        if (i_opcode == OP_LDI) begin
          o_sel  = SEL_CONST;
          o_wr_r = 1'b1;
        end else if (is_alu_op(i_opcode)) begin
          o_sel    = SEL_RES;
          o_alu_op = alu_of(i_opcode);
          o_wr_r   = 1'b1;
        end else if (i_opcode == OP_STM) begin
          o_we_m = 1'b1;
        end
      end
      WAIT_M: begin
        o_sel  = SEL_MEM;
        o_wr_r = 1'b1;
      end
      WAIT_IN: begin
        // Write and ack land in the same cycle the port presents valid data
        o_sel    = SEL_IN;
        o_wr_r   = i_in_valid;
        o_in_ack = i_in_valid;
      end
      HALT:    o_halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_controlo.sv
// Multi-cycle control unit: owns PC, IR and the FSM; strobes come from the
// decodificador sub-module.
module unidade_controlo
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [DATA_W+3:0]   Instrucao,
  input  logic                Flag_Z,
  input  logic                IN_Valid,
  output logic [ADDR_W-1:0]   PC,
  output logic [DATA_W-1:0]   Constante,
  output logic [ADDR_W-1:0]   Endereco_M,
  output logic [2:0]          SEL_Dados,
  output logic                WR_R,
  output logic                WE_M,
  output logic [2:0]          ALU_Op,
  output logic                IN_Ack,
  output logic                Halted
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W+3:0]   r_ir;
  logic [3:0]          w_opcode;
  logic                w_take_jump;

  assign w_opcode    = r_ir[DATA_W+3:DATA_W];
  assign w_take_jump = (w_opcode == OP_JMP) || ((w_opcode == OP_JZ) && Flag_Z);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        FETCH:  r_ir <= Instrucao;
        DECODE: r_pc <= r_pc + ADDR_W'(1);
        EXEC:   if (w_take_jump) r_pc <= r_ir[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (w_opcode)
          OP_LDM:  w_next = WAIT_M;
          OP_IN:   w_next = WAIT_IN;
          OP_HALT: w_next = HALT;
          default: w_next = EXEC;
        endcase
      end
      EXEC:    w_next = FETCH;
      WAIT_M:  w_next = FETCH;
      WAIT_IN: if (IN_Valid) w_next = FETCH;
      HALT:    w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  decodificador u_dec (
    .i_state    (r_state),
    .i_opcode   (w_opcode),
    .i_in_valid (IN_Valid),
    .o_sel      (SEL_Dados),
    .o_wr_r     (WR_R),
    .o_we_m     (WE_M),
    .o_alu_op   (ALU_Op),
    .o_in_ack   (IN_Ack),
    .o_halted   (Halted)
  );

  assign PC         = r_pc;
  assign Constante  = r_ir[DATA_W-1:0];
  assign Endereco_M = r_ir[ADDR_W-1:0];

endmodule

// File: tb/tb_unidade_controlo.sv
// Directed bench for unidade_controlo: a bench-owned ROM feeds Instrucao and
// every step checks hand-computed outputs at the falling clock edge.
module tb_unidade_controlo;

  logic        clk = 1'b0;
  logic        Reset;
  logic [11:0] Instrucao;
  logic        Flag_Z;
  logic        IN_Valid;
  logic [7:0]  PC;
  logic [7:0]  Constante;
  logic [7:0]  Endereco_M;
  logic [2:0]  SEL_Dados;
  logic        WR_R;
  logic        WE_M;
  logic [2:0]  ALU_Op;
  logic        IN_Ack;
  logic        Halted;

  logic [11:0] rom [0:255];
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;
  assign Instrucao = rom[PC];

  unidade_controlo #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Instrucao  (Instrucao),
    .Flag_Z     (Flag_Z),
    .IN_Valid   (IN_Valid),
    .PC         (PC),
    .Constante  (Constante),
    .Endereco_M (Endereco_M),
    .SEL_Dados  (SEL_Dados),
    .WR_R       (WR_R),
    .WE_M       (WE_M),
    .ALU_Op     (ALU_Op),
    .IN_Ack     (IN_Ack),
    .Halted     (Halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobes_idle(input string tag);
    chk({tag, "_wr"},  32'(WR_R),   32'd0);
    chk({tag, "_we"},  32'(WE_M),   32'd0);
    chk({tag, "_ack"}, 32'(IN_Ack), 32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    IN_Valid = 1'b0;
    Flag_Z   = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;

    // Reset in the middle of an IN wait
    rom[0] = 12'h400;
    repeat (2) @(negedge clk);
    chk("rst_pc",     32'(PC),        32'd0);
    chk("rst_sel",    32'(SEL_Dados), 32'd0);
    chk("rst_alu",    32'(ALU_Op),    32'd0);
    chk("rst_halted", 32'(Halted),    32'd0);
    strobes_idle("rst");
    Reset = 1'b0;                 // cycle 1 FETCH
    step();                       // cycle 2 DECODE
    step();                       // cycle 3 WAIT_IN
    chk("win_sel", 32'(SEL_Dados), 32'd2);
    chk("win_pc",  32'(PC),        32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_pc",  32'(PC),        32'd0);
    chk("arst_sel", 32'(SEL_Dados), 32'd0);
    IN_Valid = 1'b1;
    @(negedge clk);
    Reset = 1'b0;                 // cycle 1 after release, IN_Valid high
    #1;
    chk("rel_pc",  32'(PC),        32'd0);
    chk("rel_sel", 32'(SEL_Dados), 32'd0);
    strobes_idle("rel_c1");
    step();                       // cycle 2 DECODE, IN_Valid still high
    strobes_idle("rel_c2");
    chk("rel_c2_pc", 32'(PC), 32'd0);

    // Main program
    IN_Valid = 1'b0;
    Reset    = 1'b1;
    rom[0]    = 12'h105;  // LDI 5
    rom[1]    = 12'h503;  // ADD
    rom[2]    = 12'h240;  // LDM 0x40
    rom[3]    = 12'h400;  // IN
    rom[4]    = 12'hC10;  // JZ 0x10 (not taken)
    rom[5]    = 12'hC10;  // JZ 0x10 (taken)
    rom[8'h10] = 12'hBFF; // JMP 0xFF
    rom[8'hFF] = 12'h000; // NOP, PC wraps
    @(negedge clk);
    Reset = 1'b0;                 // cycle 1 FETCH LDI
    strobes_idle("c1");
    step();                       // cycle 2
    strobes_idle("c2");
    chk("c2_const", 32'(Constante), 32'h05);
    step();                       // cycle 3 EXEC LDI
    chk("ldi_wr",    32'(WR_R),      32'd1);
    chk("ldi_sel",   32'(SEL_Dados), 32'd0);
    chk("ldi_const", 32'(Constante), 32'h05);
    chk("ldi_pc",    32'(PC),        32'd1);
    step();                       // cycle 4 FETCH ADD
    strobes_idle("c4");
    step();                       // cycle 5
    strobes_idle("c5");
    step();                       // cycle 6 EXEC ADD
    chk("add_wr",  32'(WR_R),      32'd1);
    chk("add_sel", 32'(SEL_Dados), 32'd3);
    chk("add_alu", 32'(ALU_Op),    32'd0);
    chk("add_pc",  32'(PC),        32'd2);
    step();                       // cycle 7 FETCH LDM
    strobes_idle("c7");
    step();                       // cycle 8 DECODE LDM
    chk("ldm_addr_c8", 32'(Endereco_M), 32'h40);
    strobes_idle("c8");
    step();                       // cycle 9 WAIT_M
    chk("ldm_addr_c9", 32'(Endereco_M), 32'h40);
    chk("ldm_wr",      32'(WR_R),       32'd1);
    chk("ldm_sel",     32'(SEL_Dados),  32'd1);
    chk("ldm_we",      32'(WE_M),       32'd0);
    chk("ldm_pc",      32'(PC),         32'd3);
    step();                       // cycle 10 FETCH IN, stray IN_Valid
    IN_Valid = 1'b1;
    #1;
    strobes_idle("c10_stray");
    IN_Valid = 1'b0;
    step();                       // cycle 11 DECODE IN
    strobes_idle("c11");
    for (int i = 0; i < 4; i++) begin
      step();                     // cycles 12..15 WAIT_IN, no data
      chk("in_wait_sel", 32'(SEL_Dados), 32'd2);
      strobes_idle("in_wait");
    end
    step();                       // cycle 16 data arrives
    IN_Valid = 1'b1;
    #1;
    chk("in_sel", 32'(SEL_Dados), 32'd2);
    chk("in_wr",  32'(WR_R),      32'd1);
    chk("in_ack", 32'(IN_Ack),    32'd1);
    step();                       // cycle 17 FETCH JZ, IN_Valid still high
    strobes_idle("c17");
    chk("c17_pc", 32'(PC), 32'd4);
    IN_Valid = 1'b0;
    step();                       // cycle 18
    step();                       // cycle 19 EXEC JZ, Z=0
    strobes_idle("jz0");
    step();                       // cycle 20
    chk("jz0_pc", 32'(PC), 32'd5);
    Flag_Z = 1'b1;
    step();                       // cycle 21
    step();                       // cycle 22 EXEC JZ, Z=1
    step();                       // cycle 23
    chk("jz1_pc", 32'(PC), 32'h10);
    Flag_Z = 1'b0;
    step();                       // cycle 24
    step();                       // cycle 25 EXEC JMP
    step();                       // cycle 26 FETCH at 0xFF
    chk("jmp_pc", 32'(PC), 32'hFF);
    step();                       // cycle 27 DECODE NOP
    step();                       // cycle 28 EXEC NOP
    chk("wrap_pc", 32'(PC), 32'h00);
    strobes_idle("nop");
    rom[0] = 12'hF00;             // HALT fetched next at address 0
    step();                       // cycle 29 FETCH HALT
    step();                       // cycle 30 DECODE
    chk("pre_halt", 32'(Halted), 32'd0);
    step();                       // cycle 31 HALT
    chk("halt_c3", 32'(Halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      IN_Valid = i[0];
      step();
      chk("halt_hold", 32'(Halted), 32'd1);
      chk("halt_pc",   32'(PC),     32'd1);
      strobes_idle("halt");
    end
    IN_Valid = 1'b0;
    Reset = 1'b1;
    #1;
    chk("halt_rst",    32'(Halted), 32'd0);
    chk("halt_rst_pc", 32'(PC),     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_controlo.md
Name: unidade_controlo

Overview:
- Multi-cycle control unit for the 8-bit accumulator datapath.
- Fetches a 12-bit instruction from program ROM at PC, decodes it, and sequences the datapath strobes.
- Drives SEL_Dados and Constante into the R-input data mux, ALU_Op into the ALU, and write enables for register R and data memory.
- Owns PC, the instruction register (IR) and the input-port handshake.

Parameters:
- ADDR_W, 8, width of PC and data-memory address.
- DATA_W, 8, width of operand/constant field.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Instrucao  in  12  ROM word at PC; [11:8] opcode, [7:0] operand; ROM read is combinational.
- Flag_Z  in  1  zero flag from datapath, sampled in EXEC of JZ.
- IN_Valid  in  1  input port holds valid Dados_IN.
- PC  out  ADDR_W  program counter, ROM address.
- Constante  out  DATA_W  IR operand, to R-mux constant input.
- Endereco_M  out  ADDR_W  IR operand, data-memory address.
- SEL_Dados  out  3  R-mux select: 0 Constante, 1 Dados_M, 2 Dados_IN, 3 Resultado; 4-7 unused, never driven.
- WR_R  out  1  register R write enable, one-cycle pulse.
- WE_M  out  1  data-memory write enable, one-cycle pulse; memory writes R.
- ALU_Op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT.
- IN_Ack  out  1  input consumed, one-cycle pulse.
- Halted  out  1  high while in HALT.

Behaviour:
- Reset (async, active-high):
  - state=FETCH, PC=0, IR=0 (NOP).
  - WR_R=WE_M=IN_Ack=Halted=0, SEL_Dados=0, ALU_Op=0.
  - Reset asserted mid-instruction aborts it; no partial strobe is emitted after release.
- Opcodes:
  - 0 NOP, 1 LDI, 2 LDM, 3 STM, 4 IN.
  - 5-A ALU ops (ALU_Op = opcode-5).
  - B JMP, C JZ, F HALT.
  - D, E reserved; execute as NOP.
- States and transitions:
  - FETCH: IR<=Instrucao; ->DECODE.
  - DECODE: PC<=PC+1, wraps 255->0. LDM->WAIT_M; IN->WAIT_IN; HALT->HALT; all others ->EXEC.
  - EXEC: one cycle; ->FETCH.
    - LDI: SEL_Dados=0, WR_R=1.
    - ALU op: SEL_Dados=3, ALU_Op valid, WR_R=1.
    - STM: WE_M=1.
    - JMP: PC<=operand.
    - JZ: PC<=operand if Flag_Z=1, else PC unchanged.
    - NOP/reserved: no strobes.
  - WAIT_M: Endereco_M has been stable since DECODE (sync RAM, 1-cycle latency). In WAIT_M: SEL_Dados=1, WR_R=1; ->FETCH.
  - WAIT_IN: SEL_Dados=2 held.
    - While IN_Valid=0: stay, no strobes.
    - Cycle IN_Valid=1 is seen: WR_R=1 and IN_Ack=1 in the same cycle; ->FETCH.
    - Unbounded wait; no timeout.
  - HALT: Halted=1, PC frozen, no strobes; exits only via Reset.
- Latency:
  - NOP/LDI/ALU/STM/JMP/JZ: 3 cycles.
  - LDM: 3 cycles.
  - IN: 3 + wait cycles.
- Output timing:
  - Outputs are Moore-decoded from state and IR.
  - Only WR_R and IN_Ack in WAIT_IN depend combinationally on IN_Valid.
  - Constante and Endereco_M equal IR[7:0] at all times.
- Jumps: JMP/JZ to the current address (self-loop) is legal.
- Simultaneous events: IN_Valid during any state other than WAIT_IN is ignored; no IN_Ack.

Decomposition:
- Shared package ctrl_pkg: opcode constants, state enum (FETCH, DECODE, EXEC, WAIT_M, WAIT_IN, HALT), SEL_Dados codes (SEL_CONST, SEL_MEM, SEL_IN, SEL_RES), ALU_Op codes.
- Both ctrl_pkg and the R-mux use the SEL codes.
- One natural sub-module: decodificador, a combinational map from (state, opcode, IN_Valid) to the strobe vector. The FSM, PC and IR registers stay in the top.

Test Plan:
- Reset mid-WAIT_IN, then release -> PC=0, state FETCH, all strobes 0 on the first edge after release.
- ROM: 0x105 (LDI 5), 0x503 (ADD) -> LDI: WR_R=1 with SEL_Dados=0 and Constante=0x05 in cycle 3. ADD: WR_R=1 with SEL_Dados=3 and ALU_Op=0 in cycle 6. PC=2 after cycle 6.
- LDM 0x40 -> Endereco_M=0x40 from cycle 2. WR_R=1 with SEL_Dados=1 only in cycle 3. WE_M=0 throughout.
- IN with IN_Valid low 4 cycles then high -> SEL_Dados=2 throughout. Exactly one cycle with WR_R=IN_Ack=1, coinciding with the IN_Valid rise.
- JZ 0x10: Flag_Z=0 -> PC=next address. Flag_Z=1 -> PC=0x10. Separately, PC=0xFF fetch -> PC wraps to 0x00.
- HALT (0xF00) -> Halted=1 from cycle 3, PC frozen, no strobes for 20 cycles, Halted=0 after Reset.
